// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner: state enum, key
// codes in the 7-seg digit code space, column strobe patterns and the key map.
package keypad_pkg;

  localparam logic [4:0] KEY_NONE = 5'd20;

  localparam logic [3:0] COL0_STROBE = 4'b0111;
  localparam logic [3:0] COL1_STROBE = 4'b1011;
  localparam logic [3:0] COL2_STROBE = 4'b1101;
  localparam logic [3:0] COL3_STROBE = 4'b1110;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  function automatic logic [3:0] col_strobe(input logic [1:0] c);
    logic [3:0] s;
    case (c)
      2'd0:    s = COL0_STROBE;
      2'd1:    s = COL1_STROBE;
      2'd2:    s = COL2_STROBE;
      default: s = COL3_STROBE;
    endcase
    return s;
  endfunction

  // Pmod KYPD legend; the bottom row is wired 0 F E D.
  function automatic logic [4:0] keymap(input logic [1:0] r, input logic [1:0] c);
    logic [4:0] k;
    case ({r, c})
      4'h0: k = 5'd1;
      4'h1: k = 5'd2;
      4'h2: k = 5'd3;
      4'h3: k = 5'd10;
      4'h4: k = 5'd4;
      4'h5: k = 5'd5;
      4'h6: k = 5'd6;
      4'h7: k = 5'd11;
      4'h8: k = 5'd7;
      4'h9: k = 5'd8;
      4'hA: k = 5'd9;
      4'hB: k = 5'd12;
      4'hC: k = 5'd0;
      4'hD: k = 5'd15;
      4'hE: k = 5'd14;
      default: k = 5'd13;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad pins plus the decoded key stream; master is the scanner, slave is the
// keypad/consumer side.
interface keypad_scanner_if;
  import keypad_pkg::*;

  // key_valid is a one-cycle pulse with no back-pressure: a consumer must take
  // key_code in the cycle key_valid is high. key_held stays high until release.
  logic [3:0] row;
  logic [3:0] col;
  logic [4:0] key_code;
  logic       key_valid;
  logic       key_held;
  state_t     dbg_state;

  modport master (
    input  row,
    output col, key_code, key_valid, key_held, dbg_state
  );

  modport slave (
    output row,
    input  col, key_code, key_valid, key_held, dbg_state
  );

endinterface

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous, active-low keypad rows; resets idle.
module keypad_row_sync (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic [3:0] row_async,
  output logic [3:0] row_sync
);

  logic [3:0] row_meta;

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      row_meta <= 4'b1111;
      row_sync <= 4'b1111;
    end else begin
      row_meta <= row_async;
      row_sync <= row_meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column strobing, debounce, key decode and release tracking.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
  parameter int SCAN_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 20,
  parameter int REPEAT_DELAY = 50,
  parameter int REPEAT_RATE  = 10
) (
  input  logic              clock_100Mhz,
  input  logic              reset,
  keypad_scanner_if.master  kp
);
  import keypad_pkg::*;

  if (SCAN_DIV < 1 || DEBOUNCE_CNT < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
    $error("keypad_scanner: all timing parameters must be at least 1");
  end

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT + 1) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_TARGET = CW'(DEBOUNCE_CNT);
  localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CNT - 1);

  state_t         state, state_next;
  logic [DW-1:0]  dwell_cnt;
  logic [1:0]     col_idx;
  logic [1:0]     cand_row;
  logic [CW-1:0]  deb_cnt, deb_cnt_n;
  logic [CW-1:0]  rel_cnt, rel_cnt_n;
  logic [4:0]     key_code_q, key_code_n;
  logic           key_valid_q, key_valid_n;
  logic           key_held_q, key_held_n;

  logic [3:0]     row_sync;
  logic           tick;
  logic           any_low;
  logic [1:0]     low_idx;
  logic           cand_low;
  logic           col_adv;
  logic           dwell_clr;
  logic           cand_load;

`ifdef KEYPAD_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX + 1) : 1;
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);
  localparam logic [RW-1:0] R_MAX   = RW'(RMAX);

  logic [RW-1:0] rep_cnt, rep_cnt_n;
  logic          rep_first, rep_first_n;
`endif

  keypad_row_sync u_row_sync (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .row_async    (kp.row),
    .row_sync     (row_sync)
  );

  assign tick     = (dwell_cnt == DWELL_LAST);
  assign any_low  = ~&row_sync;
  assign cand_low = ~row_sync[cand_row];

  // Lowest row index wins when several rows read low in the same sample.
  always_comb begin
    low_idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row_sync[i]) low_idx = 2'(i);
    end
  end

  always_comb begin
    state_next  = state;
    col_adv     = 1'b0;
    dwell_clr   = 1'b0;
    cand_load   = 1'b0;
    deb_cnt_n   = deb_cnt;
    rel_cnt_n   = rel_cnt;
    key_code_n  = key_code_q;
    key_valid_n = 1'b0;
    key_held_n  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_n   = rep_cnt;
    rep_first_n = rep_first;
`endif
    case (state)
      SCAN: begin
        if (tick) begin
          if (any_low) begin
            cand_load = 1'b1;
            if (DEBOUNCE_CNT <= 1) begin
              state_next  = HELD;
              deb_cnt_n   = DEB_TARGET;
              rel_cnt_n   = '0;
              key_code_n  = keymap(low_idx, col_idx);
              key_valid_n = 1'b1;
              key_held_n  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_n   = '0;
              rep_first_n = 1'b1;
`endif
            end else begin
              state_next = DEBOUNCE;
              deb_cnt_n  = CW'(1);
            end
          end else begin
            col_adv = 1'b1;
          end
        end
      end
      DEBOUNCE: begin
        if (tick) begin
          if (cand_low) begin
            if (deb_cnt < DEB_TARGET) deb_cnt_n = deb_cnt + CW'(1);
            if (deb_cnt >= DEB_LAST) begin
              state_next  = HELD;
              rel_cnt_n   = '0;
              key_code_n  = keymap(cand_row, col_idx);
              key_valid_n = 1'b1;
              key_held_n  = 1'b1;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_n   = '0;
              rep_first_n = 1'b1;
`endif
            end
          end else begin
            state_next = SCAN;
            col_adv    = 1'b1;
            deb_cnt_n  = '0;
          end
        end
      end
      HELD: begin
        if (tick) begin
          if (cand_low) begin
            rel_cnt_n = '0;
`ifdef KEYPAD_REPEAT_EN
            // First repeat waits REPEAT_DELAY samples, later ones REPEAT_RATE.
            if (rep_cnt >= (rep_first ? RD_LAST : RR_LAST)) begin
              key_valid_n = 1'b1;
              rep_cnt_n   = '0;
              rep_first_n = 1'b0;
            end else if (rep_cnt < R_MAX) begin
              rep_cnt_n = rep_cnt + RW'(1);
            end
`endif
          end else begin
            if (rel_cnt < DEB_TARGET) rel_cnt_n = rel_cnt + CW'(1);
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_n = '0;
`endif
            if (rel_cnt >= DEB_LAST) begin
              state_next = RELEASE;
              key_code_n = KEY_NONE;
              key_held_n = 1'b0;
            end
          end
        end
      end
      RELEASE: begin
        // Restart the dwell so the next column gets a full settling window.
        state_next = SCAN;
        col_adv    = 1'b1;
        dwell_clr  = 1'b1;
        deb_cnt_n  = '0;
        rel_cnt_n  = '0;
      end
      default: state_next = SCAN;
    endcase
  end

  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state       <= SCAN;
      dwell_cnt   <= '0;
      col_idx     <= 2'd0;
      cand_row    <= 2'd0;
      deb_cnt     <= '0;
      rel_cnt     <= '0;
      key_code_q  <= KEY_NONE;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state       <= state_next;
      dwell_cnt   <= (dwell_clr || tick) ? '0 : dwell_cnt + DW'(1);
      if (col_adv) col_idx <= col_idx + 2'd1;
      if (cand_load) cand_row <= low_idx;
      deb_cnt     <= deb_cnt_n;
      rel_cnt     <= rel_cnt_n;
      key_code_q  <= key_code_n;
      key_valid_q <= key_valid_n;
      key_held_q  <= key_held_n;
    end
  end

`ifdef KEYPAD_REPEAT_EN
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else begin
      rep_cnt   <= rep_cnt_n;
      rep_first <= rep_first_n;
    end
  end
`endif

  assign kp.col       = col_strobe(col_idx);
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;
  assign kp.dbg_state = state;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad matrix model drives the rows from the column
// strobes; expected key codes are queued at press time and popped on key_valid.
`timescale 1ns/1ps
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SCAN_DIV     = 4;
  localparam int DEBOUNCE_CNT = 3;
  localparam int REPEAT_DELAY = 4;
  localparam int REPEAT_RATE  = 2;

  // ---------------- clock / reset ----------------
  logic clock_100Mhz = 1'b0;
  logic reset        = 1'b1;
  always #5 clock_100Mhz = ~clock_100Mhz;

  int cyc = 0;
  always @(posedge clock_100Mhz) cyc++;

  keypad_scanner_if kp ();

  keypad_scanner #(
    .SCAN_DIV     (SCAN_DIV),
    .DEBOUNCE_CNT (DEBOUNCE_CNT),
    .REPEAT_DELAY (REPEAT_DELAY),
    .REPEAT_RATE  (REPEAT_RATE)
  ) dut (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .kp           (kp)
  );

  // ---------------- keypad model ----------------
  // key_mat[r][c] = 1 means the switch at row r, column c is closed.
  logic [3:0] key_mat [4];
  logic [3:0] act_cols;

  always_comb begin
    for (int c = 0; c < 4; c++) act_cols[c] = ~kp.col[3-c];
    for (int r = 0; r < 4; r++) kp.row[r] = ~|(key_mat[r] & act_cols);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [4:0] exp_q [$];
  int pulse_cyc [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  always @(negedge clock_100Mhz) begin
    if (!reset && kp.key_valid) begin
      logic [4:0] e;
      pulse_cyc.push_back(cyc);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse key_code=%0d required=no_pulse", kp.key_code);
      end else begin
        e = exp_q.pop_front();
        if (kp.key_code !== e) begin
          errors++;
          $display("FAIL pulse_code actual=%0d required=%0d", kp.key_code, e);
        end
      end
      checks++;
      if (kp.key_held !== 1'b1) begin
        errors++;
        $display("FAIL pulse_held actual=%0b required=1", kp.key_held);
      end
      checks++;
      if (kp.dbg_state == RELEASE) begin
        errors++;
        $display("FAIL pulse_in_release actual=%0d required=not_%0d", kp.dbg_state, RELEASE);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_held(input logic v, input int budget, input string name);
    int n = 0;
    while (kp.key_held !== v && n < budget) begin
      @(negedge clock_100Mhz);
      n++;
    end
    check(name, kp.key_held, v);
  endtask

  task automatic wait_col(input logic [3:0] v, input logic eq, input int budget, input string name);
    int n = 0;
    while (((kp.col === v) != eq) && n < budget) begin
      @(negedge clock_100Mhz);
      n++;
    end
    check(name, (kp.col === v), eq);
  endtask

  logic [3:0] cols_exp [4];
  logic [3:0] c0;
  int n0;
  int exp_pulses;

  initial begin
    cols_exp = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
    for (int r = 0; r < 4; r++) key_mat[r] = 4'b0000;

    // 1: reset state and idle column rotation
    repeat (3) @(negedge clock_100Mhz);
    check("rst_col", kp.col, 4'b0111);
    check("rst_code", kp.key_code, 20);
    check("rst_valid", kp.key_valid, 0);
    check("rst_held", kp.key_held, 0);
    check("rst_state", kp.dbg_state, SCAN);
    reset = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      repeat (SCAN_DIV) @(negedge clock_100Mhz);
      check("scan_col", kp.col, cols_exp[i % 4]);
    end
    check("idle_code", kp.key_code, 20);

    // 2: press r1c2 -> key 6, then release
    key_mat[1][2] = 1'b1;
    exp_q.push_back(5'd6);
    wait_held(1'b1, 80, "t2_accept");
    check("t2_code", kp.key_code, 6);
    check("t2_col_frozen", kp.col, 4'b1101);
    repeat (8) @(negedge clock_100Mhz);
    key_mat[1][2] = 1'b0;
    wait_held(1'b0, 40, "t2_release");
    check("t2_code_blank", kp.key_code, 20);
    c0 = kp.col;
    wait_col(c0, 1'b0, 10, "t2_rescan");

    // 3: one-sample bounce on r0c0 -> no pulse, back to SCAN
    wait_col(4'b0111, 1'b0, 10, "t3_leave_col0");
    wait_col(4'b0111, 1'b1, 20, "t3_enter_col0");
    key_mat[0][0] = 1'b1;
    repeat (SCAN_DIV) @(negedge clock_100Mhz);
    check("t3_debounce", kp.dbg_state, DEBOUNCE);
    key_mat[0][0] = 1'b0;
    repeat (12) @(negedge clock_100Mhz);
    check("t3_state", kp.dbg_state, SCAN);
    check("t3_code", kp.key_code, 20);
    check("t3_held", kp.key_held, 0);

    // 4: r2 and r3 low together in column 2 -> lowest row wins (9); r0c1 locked out
    key_mat[2][2] = 1'b1;
    key_mat[3][2] = 1'b1;
    exp_q.push_back(5'd9);
    wait_held(1'b1, 80, "t4_accept");
    check("t4_code", kp.key_code, 9);
    key_mat[0][1] = 1'b1;
    repeat (8) @(negedge clock_100Mhz);
    check("t4_state_held", kp.dbg_state, HELD);
    check("t4_col_frozen", kp.col, 4'b1101);
    check("t4_code_kept", kp.key_code, 9);
    exp_q.push_back(5'd2);
    key_mat[2][2] = 1'b0;
    key_mat[3][2] = 1'b0;
    wait_held(1'b0, 40, "t4_release");
    wait_held(1'b1, 80, "t4_second_accept");
    check("t4_second_code", kp.key_code, 2);
    key_mat[0][1] = 1'b0;
    wait_held(1'b0, 40, "t4_second_release");

    // 5: reset while D is held -> immediate blank, no further pulse
    key_mat[3][3] = 1'b1;
    exp_q.push_back(5'd13);
    wait_held(1'b1, 80, "t5_accept");
    check("t5_code", kp.key_code, 13);
    repeat (2) @(negedge clock_100Mhz);
    #2 reset = 1'b1;
    #1;
    check("t5_code_blank", kp.key_code, 20);
    check("t5_held", kp.key_held, 0);
    check("t5_col", kp.col, 4'b0111);
    check("t5_state", kp.dbg_state, SCAN);
    check("t5_valid", kp.key_valid, 0);
    key_mat[3][3] = 1'b0;
    repeat (3) @(negedge clock_100Mhz);
    reset = 1'b0;
    repeat (4) @(negedge clock_100Mhz);
    check("t5_after_code", kp.key_code, 20);

    // 6: hold key 5 for 20 samples
    n0 = pulse_cyc.size();
    key_mat[1][1] = 1'b1;
    exp_q.push_back(5'd5);
`ifdef KEYPAD_REPEAT_EN
    exp_pulses = 10;
    for (int i = 1; i < exp_pulses; i++) exp_q.push_back(5'd5);
`else
    exp_pulses = 1;
`endif
    wait_held(1'b1, 80, "t6_accept");
    repeat (80) @(negedge clock_100Mhz);
    key_mat[1][1] = 1'b0;
    wait_held(1'b0, 60, "t6_release");
    check("t6_pulses", pulse_cyc.size() - n0, exp_pulses);
`ifdef KEYPAD_REPEAT_EN
    if (pulse_cyc.size() >= n0 + 3) begin
      check("t6_first_gap", pulse_cyc[n0+1] - pulse_cyc[n0], 4 * SCAN_DIV);
      check("t6_rate_gap", pulse_cyc[n0+2] - pulse_cyc[n0+1], 2 * SCAN_DIV);
    end
`endif
    check("t6_code_blank", kp.key_code, 20);

    repeat (10) @(negedge clock_100Mhz);
    check("sb_drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
